// File: rtl/threshold_trigger_pkg.sv
// Shared constants for the threshold trigger: default widths and FSM encoding.
package threshold_trigger_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int CNT_W_DEF  = 16;
   localparam int EVT_W_DEF  = 32;

   // Encoding is visible to software through state_o, so values are fixed.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_QUALIFY = 3'd2,
      ST_HOLDOFF = 3'd3,
      ST_REARM   = 3'd4
   } state_e;

   // Dwell of zero behaves like a dwell of one.
   function automatic logic [CNT_W_DEF-1:0] dwell_floor1(input logic [CNT_W_DEF-1:0] d);
      return (d == '0) ? CNT_W_DEF'(1) : d;
   endfunction

endpackage

// File: rtl/threshold_trigger_sat_counter.sv
// Saturating event counter: synchronous clear has priority over increment,
// so a clear and an increment in the same cycle leave the count at one.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   // Clear first, then increment unless already at all-ones.
   always_comb begin
      count_d = clr ? '0 : count_q;
      if (inc && (count_d != '1)) begin
         count_d = count_d + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/threshold_trigger.sv
// Hysteretic threshold trigger with dwell qualification, holdoff dead time,
// peak capture and a saturating fire counter.
module threshold_trigger
   import threshold_trigger_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int EVT_W  = EVT_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic signed [DATA_W-1:0] din,
   input  logic signed [DATA_W-1:0] thr_hi,
   input  logic signed [DATA_W-1:0] thr_lo,
   input  logic        [CNT_W-1:0]  dwell,
   input  logic        [CNT_W-1:0]  holdoff,
   input  logic                     clr_count,
   output logic                     trig,
   output logic                     armed,
   output logic        [2:0]        state_o,
   output logic signed [DATA_W-1:0] peak,
   output logic        [EVT_W-1:0]  evt_count,
   output logic                     cfg_err
);

   state_e                    state_q, state_d;
   logic                      trig_q, trig_d;
   logic                      cfg_err_q, cfg_err_d;
   logic signed [DATA_W-1:0]  peak_q, peak_d;
   logic signed [DATA_W-1:0]  run_max_q, run_max_d;
   logic        [CNT_W-1:0]   run_cnt_q, run_cnt_d;
   logic        [CNT_W-1:0]   need_q, need_d;     // dwell latched for this run
   logic        [CNT_W-1:0]   hold_q, hold_d;     // remaining holdoff cycles
   logic        [CNT_W-1:0]   dwell_eff;
   logic        [CNT_W-1:0]   run_nxt;
   logic                      ge_hi, le_lo;
   logic                      fire;

   assign ge_hi     = (din >= thr_hi);
   assign le_lo     = (din <= thr_lo);
   assign dwell_eff = (dwell == '0) ? CNT_W'(1) : dwell;
   assign run_nxt   = run_cnt_q + CNT_W'(1);

   // Next-state, run tracking and fire decision.
   always_comb begin
      state_d   = state_q;
      trig_d    = 1'b0;
      peak_d    = peak_q;
      run_max_d = run_max_q;
      run_cnt_d = run_cnt_q;
      need_d    = need_q;
      hold_d    = hold_q;
      fire      = 1'b0;
      cfg_err_d = (thr_lo > thr_hi);

      if (!enable || cfg_err_q) begin
         // Disarm: counters cleared, peak and event count kept.
         state_d   = ST_IDLE;
         run_cnt_d = '0;
         hold_d    = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_ARMED;
            end
            ST_ARMED: begin
               if (ge_hi) begin
                  run_cnt_d = CNT_W'(1);
                  run_max_d = din;
                  need_d    = dwell_eff;
                  if (dwell_eff == CNT_W'(1)) begin
                     fire = 1'b1;
                  end else begin
                     state_d = ST_QUALIFY;
                  end
               end
            end
            ST_QUALIFY: begin
               if (ge_hi) begin
                  run_cnt_d = run_nxt;
                  if (din > run_max_q) begin
                     run_max_d = din;
                  end
                  if (run_nxt >= need_q) begin
                     fire = 1'b1;
                  end
               end else begin
                  // Broken run: drop back without touching peak.
                  run_cnt_d = '0;
                  state_d   = ST_ARMED;
               end
            end
            ST_HOLDOFF: begin
               // din is ignored; leave after exactly the latched count.
               if (hold_q <= CNT_W'(1)) begin
                  hold_d  = '0;
                  state_d = ST_REARM;
               end else begin
                  hold_d = hold_q - CNT_W'(1);
               end
            end
            ST_REARM: begin
               // The re-arming sample is not also tested against thr_hi.
               if (le_lo) begin
                  state_d = ST_ARMED;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         if (fire) begin
            trig_d    = 1'b1;
            peak_d    = run_max_d;
            run_cnt_d = '0;
            hold_d    = holdoff;
            state_d   = (holdoff == '0) ? ST_REARM : ST_HOLDOFF;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         trig_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         peak_q    <= '0;
         run_max_q <= '0;
         run_cnt_q <= '0;
         need_q    <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         trig_q    <= trig_d;
         cfg_err_q <= cfg_err_d;
         peak_q    <= peak_d;
         run_max_q <= run_max_d;
         run_cnt_q <= run_cnt_d;
         need_q    <= need_d;
         hold_q    <= hold_d;
      end
   end

   sat_counter #(
      .W (EVT_W)
   ) u_evt (
      .clk   (clk),
      .rst_n (reset),
      .clr   (clr_count),
      .inc   (fire),
      .count (evt_count)
   );

   assign trig    = trig_q;
   assign armed   = (state_q == ST_ARMED) || (state_q == ST_QUALIFY);
   assign state_o = state_q;
   assign peak    = peak_q;
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_threshold_trigger.sv
// Bench for threshold_trigger: directed corner sequences, a config-error
// vector table, and a randomized run against a reference model.
module tb_threshold_trigger;

   localparam longint EVT_MAX = 64'hFFFF_FFFF;

   logic               clk = 1'b0;
   logic               reset;
   logic               enable;
   logic signed [15:0] din, thr_hi, thr_lo;
   logic        [15:0] dwell, holdoff;
   logic               clr_count;
   logic               trig, armed, cfg_err;
   logic        [2:0]  state_o;
   logic signed [15:0] peak;
   logic        [31:0] evt_count;

   int n_chk = 0;
   int n_err = 0;

   threshold_trigger dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .din       (din),
      .thr_hi    (thr_hi),
      .thr_lo    (thr_lo),
      .dwell     (dwell),
      .holdoff   (holdoff),
      .clr_count (clr_count),
      .trig      (trig),
      .armed     (armed),
      .state_o   (state_o),
      .peak      (peak),
      .evt_count (evt_count),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference model: trigger behaviour expressed as plain rule steps.
   int     m_st, m_run, m_max, m_need, m_dead, m_peak;
   bit     m_trig, m_cfg;
   longint m_evt;

   task automatic model_reset();
      m_st = 0; m_run = 0; m_max = 0; m_need = 0; m_dead = 0; m_peak = 0;
      m_trig = 0; m_cfg = 0; m_evt = 0;
   endtask

   task automatic model_step();
      bit f = 0;
      int d  = int'(din);
      int hi = int'(thr_hi);
      int lo = int'(thr_lo);
      bit new_cfg = (lo > hi);
      if (!enable || m_cfg) begin
         m_st = 0; m_run = 0; m_dead = 0;
      end else begin
         case (m_st)
            0: m_st = 1;
            1: if (d >= hi) begin
                  m_run = 1; m_max = d;
                  m_need = (dwell == 0) ? 1 : int'(dwell);
                  if (m_need == 1) f = 1; else m_st = 2;
               end
            2: if (d >= hi) begin
                  m_run++;
                  if (d > m_max) m_max = d;
                  if (m_run >= m_need) f = 1;
               end else m_st = 1;
            3: begin
                  m_dead--;
                  if (m_dead == 0) m_st = 4;
               end
            default: if (d <= lo) m_st = 1;
         endcase
      end
      if (clr_count) m_evt = 0;
      if (f) begin
         m_peak = m_max;
         if (m_evt < EVT_MAX) m_evt++;
         m_dead = int'(holdoff);
         m_st = (holdoff == 0) ? 4 : 3;
      end
      m_trig = f;
      m_cfg  = new_cfg;
   endtask

   typedef struct {
      logic signed [15:0] hi;
      logic signed [15:0] lo;
      logic               cfg;
   } cfg_vec_t;

   cfg_vec_t vec[8];
   int       seq37[6];
   int       ntrig;
   logic [53:0] act_v, exp_v;

   initial begin
      vec[0] = '{16'sd100,   16'sd50,    1'b0};
      vec[1] = '{16'sd100,   16'sd100,   1'b0};
      vec[2] = '{16'sd100,   16'sd101,   1'b1};
      vec[3] = '{-16'sd1,    -16'sd2,    1'b0};
      vec[4] = '{-16'sd2,    -16'sd1,    1'b1};
      vec[5] = '{16'sh7FFF,  16'sh8000,  1'b0};
      vec[6] = '{16'sh8000,  16'sh7FFF,  1'b1};
      vec[7] = '{16'sd0,     -16'sd1,    1'b0};
      seq37  = '{120, 130, 90, 120, 125, 140};

      reset = 1'b0; enable = 1'b0; din = '0; thr_hi = 16'sd100; thr_lo = 16'sd50;
      dwell = 16'd1; holdoff = 16'd0; clr_count = 1'b0;
      tick(); tick();
      chk("rst_state", 64'(state_o), 0);
      chk("rst_trig", 64'(trig), 0);
      chk("rst_armed", 64'(armed), 0);
      chk("rst_peak", 64'(peak), 0);
      chk("rst_evt", 64'(evt_count), 0);
      chk("rst_cfg", 64'(cfg_err), 0);

      // Single-sample fire, no holdoff.
      reset = 1'b1; enable = 1'b1;
      tick();
      chk("arm_state", 64'(state_o), 1);
      chk("arm_armed", 64'(armed), 1);
      tick();
      din = 16'sd120;
      tick();
      chk("step_trig", 64'(trig), 1);
      chk("step_evt", 64'(evt_count), 1);
      chk("step_peak", 64'(peak), 120);
      chk("step_state", 64'(state_o), 4);
      tick();
      chk("step_trig_off", 64'(trig), 0);
      din = 16'sd40;
      tick();
      chk("rearm_state", 64'(state_o), 1);

      // Dwell of three with a broken first run.
      dwell = 16'd3;
      for (int i = 0; i < 6; i++) begin
         din = 16'(seq37[i]);
         tick();
         chk($sformatf("dwell_trig%0d", i), 64'(trig), (i == 5) ? 1 : 0);
      end
      chk("dwell_peak", 64'(peak), 140);
      chk("dwell_evt", 64'(evt_count), 2);
      din = 16'sd40;
      tick();

      // Holdoff of ten with din stuck high.
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      chk("clr_evt", 64'(evt_count), 0);
      dwell = 16'd1; holdoff = 16'd10; din = 16'sd200;
      tick();
      chk("ho_trig", 64'(trig), 1);
      chk("ho_state", 64'(state_o), 3);
      ntrig = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         ntrig += int'(trig);
         if (i == 9)  chk("ho_state9", 64'(state_o), 3);
         if (i == 10) chk("ho_state10", 64'(state_o), 4);
      end
      chk("ho_ntrig", 64'(ntrig), 0);
      din = 16'sd40;
      tick();
      chk("ho_rearm", 64'(state_o), 1);
      din = 16'sd200;
      tick();
      chk("ho_trig2", 64'(trig), 1);
      chk("ho_evt2", 64'(evt_count), 2);

      // Inverted thresholds.
      din = '0; thr_lo = 16'sd150;
      tick();
      chk("cfg_flag", 64'(cfg_err), 1);
      tick();
      chk("cfg_idle", 64'(state_o), 0);
      thr_lo = 16'sd50;
      tick();
      chk("cfg_clear", 64'(cfg_err), 0);
      chk("cfg_still_idle", 64'(state_o), 0);
      tick();
      chk("cfg_armed", 64'(state_o), 1);

      // Signed threshold comparison table.
      enable = 1'b0;
      foreach (vec[i]) begin
         thr_hi = vec[i].hi; thr_lo = vec[i].lo;
         tick();
         chk($sformatf("cfg_vec%0d", i), 64'(cfg_err), 64'(vec[i].cfg));
      end
      thr_hi = 16'sd100; thr_lo = 16'sd50; enable = 1'b1;
      tick(); tick(); tick();
      chk("vec_rearm", 64'(state_o), 1);

      // Enable dropped mid-qualify; next run needs a full fresh dwell.
      dwell = 16'd4; holdoff = 16'd3; din = 16'sd120;
      tick();
      chk("q_state", 64'(state_o), 2);
      tick();
      enable = 1'b0;
      tick();
      chk("q_drop_state", 64'(state_o), 0);
      chk("q_drop_trig", 64'(trig), 0);
      enable = 1'b1; din = '0;
      tick();
      din = 16'sd120;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("q_trig%0d", i), 64'(trig), (i == 3) ? 1 : 0);
      end

      // Asynchronous reset mid-holdoff, then release latency.
      din = '0;
      tick();
      chk("r_ho_state", 64'(state_o), 3);
      #2 reset = 1'b0;
      #1;
      chk("r_state", 64'(state_o), 0);
      chk("r_evt", 64'(evt_count), 0);
      chk("r_trig", 64'(trig), 0);
      chk("r_peak", 64'(peak), 0);
      tick();
      reset = 1'b1; din = 16'sd200; dwell = 16'd1;
      tick();
      chk("rel_trig1", 64'(trig), 0);
      tick();
      chk("rel_trig2", 64'(trig), 1);

      // Saturation and clear/fire collision.
      holdoff = 16'd0; din = '0;
      repeat (5) tick();
      chk("sat_armed", 64'(state_o), 1);
      force dut.u_evt.count_q = 32'hFFFF_FFFF;
      tick();
      release dut.u_evt.count_q;
      din = 16'sd120;
      tick();
      chk("sat_trig", 64'(trig), 1);
      chk("sat_evt", 64'(evt_count), 64'hFFFF_FFFF);
      din = 16'sd40;
      tick();
      din = 16'sd120; clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      chk("clrfire_trig", 64'(trig), 1);
      chk("clrfire_evt", 64'(evt_count), 1);

      // Randomized run against the model.
      reset = 1'b0; enable = 1'b0; din = '0; clr_count = 1'b0;
      thr_hi = 16'sd20; thr_lo = -16'sd20; dwell = 16'd2; holdoff = 16'd3;
      model_reset();
      tick();
      reset = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 249) begin
            int h = int'($urandom_range(0, 80)) - 30;
            int l = ($urandom_range(0, 99) < 15) ? h + 1 + int'($urandom_range(0, 20))
                                                 : h - int'($urandom_range(0, 40));
            thr_hi = 16'(h); thr_lo = 16'(l);
         end
         if ($urandom_range(0, 9) == 0) dwell   = 16'($urandom_range(0, 4));
         if ($urandom_range(0, 9) == 0) holdoff = 16'($urandom_range(0, 6));
         enable    = ($urandom_range(0, 99) < 97);
         clr_count = ($urandom_range(0, 99) < 3);
         din       = 16'(int'($urandom_range(0, 200)) - 100);
         model_step();
         tick();
         act_v = {trig, armed, state_o, cfg_err, peak, evt_count};
         exp_v = {m_trig, (m_st == 1 || m_st == 2), 3'(m_st), m_cfg, 16'(m_peak), 32'(m_evt)};
         chk($sformatf("rand%0d", c), 64'(act_v), 64'(exp_v));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/threshold_trigger.md
THRESHOLD_TRIGGER -- requirements
Module: threshold_trigger

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample and threshold width (signed).
REQ-002 SHALL have parameter CNT_W, default 16, width of the dwell and holdoff counters.
REQ-003 SHALL have parameter EVT_W, default 32, width of the event counter.
REQ-004 SHALL have port clk  in  1  single clock domain; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  arms the detector when high.
REQ-007 SHALL have port din  in  DATA_W signed  filtered sample stream, one sample per clock (moving-average output).
REQ-008 SHALL have port thr_hi  in  DATA_W signed  upper (fire) threshold.
REQ-009 SHALL have port thr_lo  in  DATA_W signed  lower (re-arm) threshold.
REQ-010 SHALL have port dwell  in  CNT_W  number of consecutive samples >= thr_hi required to fire; 0 is treated as 1.
REQ-011 SHALL have port holdoff  in  CNT_W  cycles of forced dead time after a fire.
REQ-012 SHALL have port clr_count  in  1  single-cycle synchronous clear of evt_count.
REQ-013 SHALL have port trig  out  1  single-cycle registered fire pulse.
REQ-014 SHALL have port armed  out  1  high in ARMED or QUALIFY.
REQ-015 SHALL have port state_o  out  3  encoded FSM state, for the status registers.
REQ-016 SHALL have port peak  out  DATA_W signed  largest din seen during the last qualify run; updated on fire.
REQ-017 SHALL have port evt_count  out  EVT_W  saturating count of fires.
REQ-018 SHALL have port cfg_err  out  1  registered flag, high while thr_lo > thr_hi.

Function
REQ-019 SHALL implement FSM states IDLE=0, ARMED=1, QUALIFY=2, HOLDOFF=3, REARM=4.
REQ-020 SHALL go from any state to IDLE on the next edge when enable=0 or cfg_err=1, clearing the dwell and holdoff counters; evt_count and peak are retained.
REQ-021 SHALL go from IDLE to ARMED when enable=1 and cfg_err=0.
REQ-022 SHALL, in ARMED on a sample din>=thr_hi: set run count=1 and run max=din; if max(dwell,1)==1, fire, otherwise enter QUALIFY.
REQ-023 SHALL, in QUALIFY, increment run count and update run max on each din>=thr_hi, and fire when run count reaches max(dwell,1).
REQ-024 SHALL return from QUALIFY to ARMED on any din<thr_hi, without firing and without changing peak.
REQ-025 SHALL, on fire: assert trig for exactly the cycle after the qualifying edge (latency 1); load peak with the run max including the current sample; increment evt_count, saturating at all-ones; enter HOLDOFF, or REARM if holdoff=0.
REQ-026 SHALL stay in HOLDOFF for exactly holdoff cycles, ignoring din, then enter REARM.
REQ-027 SHALL go from REARM to ARMED on the first din<=thr_lo; the same sample is not evaluated against thr_hi.
REQ-028 SHALL use full signed DATA_W comparisons; thr_lo==thr_hi is legal (zero hysteresis).
REQ-029 SHALL sample dwell and holdoff once on entry to QUALIFY and HOLDOFF respectively; mid-run changes take effect on the next run.
REQ-030 SHALL, when clr_count and a fire coincide, leave evt_count=1 (clear first, then increment).
REQ-031 SHALL hold trig low in every cycle that is not the fire cycle; back-to-back fires are impossible because holdoff>=0 plus REARM occupies at least one cycle.

Reset
REQ-032 SHALL, with reset low, force state IDLE, trig=0, armed=0, state_o=0, peak=0, evt_count=0, cfg_err=0, and all counters to 0, asynchronously.
REQ-033 SHALL release from reset synchronously on the first edge after reset goes high; a fire cannot occur until at least two edges after release.

Structure
REQ-034 SHALL place the state encoding constants and the DATA_W/CNT_W/EVT_W defaults in shared package threshold_trigger_pkg.
REQ-035 SHALL implement evt_count in sub-module sat_counter (sync clear, increment, saturate), instantiated once.

Verification
REQ-036 SHALL cover: dwell=1, holdoff=0, thr_hi=100, thr_lo=50, din step 0->120 at edge k -> trig high in cycle k+1 only, evt_count=1, peak=120, state_o=4.
REQ-037 SHALL cover: dwell=3, din=120,130,90,120,125,140 -> no fire on the first run; trig after the 6th sample; peak=140.
REQ-038 SHALL cover: holdoff=10, din held at 200 -> one trig only; after din falls to 40, re-arm; a new 200 step gives the second trig; evt_count=2.
REQ-039 SHALL cover: thr_lo=150, thr_hi=100 -> cfg_err=1 and state IDLE; restoring thr_lo=50 -> ARMED two cycles later.
REQ-040 SHALL cover: enable dropped mid-QUALIFY, and reset asserted mid-HOLDOFF -> IDLE with no trig; the reset case also gives evt_count=0.
REQ-041 SHALL cover: evt_count preloaded to all-ones by forcing, then a fire -> stays all-ones; clr_count coincident with a fire -> evt_count=1.
